parity_screen_fifo: RTL and testbench

PARITY_SCREEN_FIFO -- requirements
Module: parity_screen_fifo

---
 rtl/parity_screen_fifo.sv | 102 ++++++++++
 tb/tb_parity_screen_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_screen_fifo.sv
// Synchronous FIFO that screens incoming words for parity errors.
// Bad words are either dropped or stored with an error flag, and they are counted.
module parity_screen_fifo #(
    parameter int   FIFO_DEPTH = 4,
    parameter int   DATA_WIDTH = 17,
    parameter logic PARITY     = 1'b1,
    parameter logic P_BIT      = 1'b1,
    parameter logic DROP_ERR   = 1'b1,
    parameter int   AF_THRESH  = FIFO_DEPTH - 1,
    parameter int   ERR_CNT_W  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic                            grant_out,
    output logic                            valid_out,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            data_out_err,
    input  logic                            grant_in,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            almost_full,
    output logic                            parity_err,
    output logic [ERR_CNT_W-1:0]            err_cnt,
    input  logic                            err_clr
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PAR_IDX = P_BIT ? 0 : DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] PAYLOAD_MASK = ~(DATA_WIDTH'(1) << PAR_IDX);
    localparam logic [ERR_CNT_W-1:0]  ERR_MAX      = '1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] err_mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  payload_par;
    logic                  word_bad;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  store;
    logic                  bad_acc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Payload parity folded with the parity bit equals the XOR of the whole word.
    assign payload_par = ^(data_in & PAYLOAD_MASK);
    assign word_bad    = (payload_par ^ data_in[PAR_IDX]) != ~PARITY;

    assign grant_out    = rst_n & (count < CNT_W'(FIFO_DEPTH));
    assign valid_out    = (count != '0);
    assign in_xfer      = valid_in & grant_out;
    assign out_xfer     = valid_out & grant_in;
    assign bad_acc      = in_xfer & word_bad;
    assign store        = in_xfer & (~word_bad | ~DROP_ERR);
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign data_out     = valid_out ? mem[rd_ptr] : '0;
    assign data_out_err = valid_out ? err_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr]     <= data_in;
            err_mem[wr_ptr] <= word_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)
                wr_ptr <= ptr_inc(wr_ptr);
            if (out_xfer)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({store, out_xfer})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A clear in the same cycle as a bad word leaves that word counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
            err_cnt    <= '0;
        end else begin
            parity_err <= bad_acc;
            if (err_clr)
                err_cnt <= bad_acc ? ERR_CNT_W'(1) : '0;
            else if (bad_acc && err_cnt != ERR_MAX)
                err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_screen_fifo.sv
// Directed self-checking bench for parity_screen_fifo.
// Three instances cover drop mode, flag mode, and a depth-3 FIFO with a 2-bit error counter.
module tb_parity_screen_fifo;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_grant_in, a_err_clr;
    logic [16:0] a_data;
    logic        a_grant_out, a_valid_out, a_data_out_err, a_almost_full, a_parity_err;
    logic [16:0] a_data_out;
    logic [2:0]  a_count;
    logic [7:0]  a_err_cnt;

    logic        b_valid, b_grant_in, b_err_clr;
    logic [16:0] b_data;
    logic        b_grant_out, b_valid_out, b_data_out_err, b_almost_full, b_parity_err;
    logic [16:0] b_data_out;
    logic [2:0]  b_count;
    logic [7:0]  b_err_cnt;

    logic        c_valid, c_grant_in, c_err_clr;
    logic [16:0] c_data;
    logic        c_grant_out, c_valid_out, c_data_out_err, c_almost_full, c_parity_err;
    logic [16:0] c_data_out;
    logic [1:0]  c_count;
    logic [1:0]  c_err_cnt;

    int checks;
    int failures;
    logic [16:0] fill_words [4];

    parity_screen_fifo u_a (
        .clk(clk), .rst_n(rst_n), .valid_in(a_valid), .data_in(a_data),
        .grant_out(a_grant_out), .valid_out(a_valid_out), .data_out(a_data_out),
        .data_out_err(a_data_out_err), .grant_in(a_grant_in), .count(a_count),
        .almost_full(a_almost_full), .parity_err(a_parity_err), .err_cnt(a_err_cnt),
        .err_clr(a_err_clr)
    );

    parity_screen_fifo #(.DROP_ERR(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .valid_in(b_valid), .data_in(b_data),
        .grant_out(b_grant_out), .valid_out(b_valid_out), .data_out(b_data_out),
        .data_out_err(b_data_out_err), .grant_in(b_grant_in), .count(b_count),
        .almost_full(b_almost_full), .parity_err(b_parity_err), .err_cnt(b_err_cnt),
        .err_clr(b_err_clr)
    );

    parity_screen_fifo #(.FIFO_DEPTH(3), .ERR_CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .valid_in(c_valid), .data_in(c_data),
        .grant_out(c_grant_out), .valid_out(c_valid_out), .data_out(c_data_out),
        .data_out_err(c_data_out_err), .grant_in(c_grant_in), .count(c_count),
        .almost_full(c_almost_full), .parity_err(c_parity_err), .err_cnt(c_err_cnt),
        .err_clr(c_err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [16:0] data, input logic grant);
        a_valid    = valid;
        a_data     = data;
        a_grant_in = grant;
    endtask

    // Even-parity word with parity in bit 0 and a distinct payload per index.
    function automatic logic [16:0] good_word(input int i);
        logic [16:0] w;
        w    = {16'(i * 3 + 1), 1'b0};
        w[0] = ^w[16:1];
        return w;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        a_valid = 0; a_grant_in = 0; a_err_clr = 0; a_data = '0;
        b_valid = 0; b_grant_in = 0; b_err_clr = 0; b_data = '0;
        c_valid = 0; c_grant_in = 0; c_err_clr = 0; c_data = '0;
        fill_words[0] = 17'h00003;
        fill_words[1] = 17'h00005;
        fill_words[2] = 17'h00006;
        fill_words[3] = 17'h00009;

        #2;
        checkOutput("rst_count",     a_count,       0);
        checkOutput("rst_valid_out", a_valid_out,   0);
        checkOutput("rst_grant_out", a_grant_out,   0);
        checkOutput("rst_af",        a_almost_full, 0);
        checkOutput("rst_perr",      a_parity_err,  0);
        checkOutput("rst_err_cnt",   a_err_cnt,     0);
        checkOutput("rst_data_out",  a_data_out,    0);

        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("grant_after_rst", a_grant_out, 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, fill_words[i], 1'b0);
            tick();
            checkOutput("fill_count", a_count, i + 1);
            checkOutput("fill_af", a_almost_full, (i + 1 >= 3) ? 1 : 0);
        end
        checkOutput("full_grant", a_grant_out, 0);
        checkOutput("full_head",  a_data_out,  17'h00003);

        applyStimulus(1'b1, 17'h00011, 1'b0);
        tick();
        checkOutput("fifth_not_taken", a_count,    4);
        checkOutput("fifth_head",      a_data_out, 17'h00003);

        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_data", a_data_out, fill_words[i]);
            tick();
        end
        checkOutput("drain_count", a_count,     0);
        checkOutput("drain_valid", a_valid_out, 0);
        checkOutput("drain_zero",  a_data_out,  0);

        applyStimulus(1'b1, 17'h00001, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("drop_perr",    a_parity_err, 1);
        checkOutput("drop_err_cnt", a_err_cnt,    1);
        checkOutput("drop_count",   a_count,      0);
        checkOutput("drop_valid",   a_valid_out,  0);
        tick();
        checkOutput("drop_perr_end", a_parity_err, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, fill_words[i], 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("midop_count", a_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid",   a_valid_out, 0);
        checkOutput("midrst_count",   a_count,     0);
        checkOutput("midrst_err_cnt", a_err_cnt,   0);
        checkOutput("midrst_grant",   a_grant_out, 0);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_grant_up", a_grant_out, 1);
        applyStimulus(1'b1, 17'h00009, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_valid", a_valid_out, 1);
        checkOutput("post_rst_head",  a_data_out,  17'h00009);
        checkOutput("post_rst_count", a_count,     1);

        b_valid = 1'b1;
        b_data  = 17'h00001;
        tick();
        checkOutput("flag_perr", b_parity_err, 1);
        b_data = 17'h00003;
        tick();
        b_valid = 1'b0;
        checkOutput("flag_count",    b_count,        2);
        checkOutput("flag_head",     b_data_out,     17'h00001);
        checkOutput("flag_head_err", b_data_out_err, 1);
        checkOutput("flag_err_cnt",  b_err_cnt,      1);
        b_grant_in = 1'b1;
        tick();
        checkOutput("flag_next",     b_data_out,     17'h00003);
        checkOutput("flag_next_err", b_data_out_err, 0);
        tick();
        checkOutput("flag_empty", b_valid_out, 0);
        b_grant_in = 1'b0;

        for (int i = 0; i < 10; i++) begin
            c_data     = good_word(i);
            c_valid    = 1'b1;
            c_grant_in = 1'b1;
            tick();
            checkOutput("stream_data",  c_data_out, good_word(i));
            checkOutput("stream_count", c_count,    1);
        end
        c_valid = 1'b0;
        tick();
        checkOutput("stream_end_count", c_count, 0);
        c_grant_in = 1'b0;

        for (int i = 0; i < 3; i++) begin
            c_data  = good_word(20 + i);
            c_valid = 1'b1;
            tick();
        end
        checkOutput("c_full_count", c_count,       3);
        checkOutput("c_full_grant", c_grant_out,   0);
        checkOutput("c_full_af",    c_almost_full, 1);
        c_data     = good_word(30);
        c_grant_in = 1'b1;
        tick();
        checkOutput("c_read_only_count", c_count,    2);
        checkOutput("c_read_only_head",  c_data_out, good_word(21));
        c_valid = 1'b0;
        tick();
        checkOutput("c_wrap_head", c_data_out, good_word(22));
        tick();
        checkOutput("c_drained", c_count, 0);
        c_grant_in = 1'b0;

        for (int i = 0; i < 5; i++) begin
            c_valid = 1'b1;
            c_data  = 17'h00001;
            tick();
            checkOutput("sat_err_cnt", c_err_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        checkOutput("sat_count", c_count, 0);
        c_err_clr = 1'b1;
        tick();
        checkOutput("clr_with_bad", c_err_cnt, 1);
        c_valid = 1'b0;
        tick();
        checkOutput("clr_alone", c_err_cnt, 0);
        c_err_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
